// File: rtl/gated_alu_pipe.sv
`timescale 1ns/1ps
// Two-stage valid/ready ALU whose pipeline registers run on a latch-based clock
// gate that closes after IDLE_CYCLES quiet cycles. GATE_STATS_EN adds a gated-cycle counter.
module gated_alu_pipe #(
  parameter int WIDTH       = 8,
  parameter int IDLE_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             flag_neg,
  output logic             clk_gated,
  output logic [CNT_W-1:0] gated_cycles
);

  localparam int MSB    = WIDTH - 1;
  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;

  logic              s1_valid;
  logic              s2_valid;
  logic [WIDTH-1:0]  s1_a;
  logic [WIDTH-1:0]  s1_b;
  logic [2:0]        s1_op;
  logic              s1_adv;
  logic [IDLE_W-1:0] idle_cnt;
  logic              gate_en;
  logic              gate_q;
  logic              gclk;

  logic [WIDTH:0]    sum;
  logic [WIDTH:0]    diff;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_carry;
  logic              alu_ovf;

  // ---------------------------------------------------------------------------
  // Clock gate
  // ---------------------------------------------------------------------------
  assign gate_en   = in_valid | s1_valid | s2_valid | (idle_cnt != '0);
  assign clk_gated = !gate_en;

  // Enable is captured while clk is low so gclk can only change on clk's rising edge.
  always_latch begin
    if (!clk) gate_q <= gate_en;
  end

  assign gclk = clk & gate_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= '0;
    end else if (in_valid || s1_valid || s2_valid) begin
      idle_cnt <= IDLE_W'(IDLE_CYCLES);
    end else if (idle_cnt != '0) begin
      idle_cnt <= idle_cnt - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake and stage valids (gated clock)
  // ---------------------------------------------------------------------------
  assign s1_adv    = !s2_valid | out_ready;
  assign in_ready  = !s1_valid | s1_adv;
  assign out_valid = s2_valid;

  always_ff @(posedge gclk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s1_adv)   s2_valid <= s1_valid;
    end
  end

  // NOTE: operand registers carry no reset; s1_valid alone decides whether they mean anything.
  always_ff @(posedge gclk) begin
    if (in_valid && in_ready) begin
      s1_a  <= a;
      s1_b  <= b;
      s1_op <= op;
    end
  end

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  assign sum  = {1'b0, s1_a} + {1'b0, s1_b};
  assign diff = {1'b0, s1_a} - {1'b0, s1_b};

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    alu_res   = s1_a;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (s1_op)
      OP_ADD: begin
        alu_res   = sum[MSB:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (s1_a[MSB] == s1_b[MSB]) && (sum[MSB] != s1_a[MSB]);
      end
      OP_SUB: begin
        alu_res   = diff[MSB:0];
        alu_carry = !diff[WIDTH];
        alu_ovf   = (s1_a[MSB] != s1_b[MSB]) && (diff[MSB] != s1_a[MSB]);
      end
      OP_AND: alu_res = s1_a & s1_b;
      OP_OR:  alu_res = s1_a | s1_b;
      OP_XOR: alu_res = s1_a ^ s1_b;
      OP_SHL: begin
        alu_res   = {s1_a[MSB-1:0], 1'b0};
        alu_carry = s1_a[MSB];
      end
      OP_SHR: begin
        alu_res   = {1'b0, s1_a[MSB:1]};
        alu_carry = s1_a[0];
      end
      default: alu_res = s1_a;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge gclk or negedge reset_n) begin
    if (!reset_n) begin
      result     <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_ovf   <= 1'b0;
      flag_neg   <= 1'b0;
    end else if (s1_adv && s1_valid) begin
      result     <= alu_res;
      flag_zero  <= (alu_res == '0);
      flag_carry <= alu_carry;
      flag_ovf   <= alu_ovf;
      flag_neg   <= alu_res[MSB];
    end
  end

  // ---------------------------------------------------------------------------
  // Gated-cycle statistics (free clock)
  // ---------------------------------------------------------------------------
`ifdef GATE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gated_cycles <= '0;
    end else if (clk_gated && (gated_cycles != '1)) begin
      gated_cycles <= gated_cycles + 1'b1;
    end
  end
`else
  assign gated_cycles = '0;
`endif

endmodule

// File: tb/tb_gated_alu_pipe.sv
`timescale 1ns/1ps
// Directed self-checking bench for gated_alu_pipe (WIDTH=8, IDLE_CYCLES=4).
module tb_gated_alu_pipe;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [2:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  result;
  logic        flag_zero;
  logic        flag_carry;
  logic        flag_ovf;
  logic        flag_neg;
  logic        clk_gated;
  logic [15:0] gated_cycles;
  logic [3:0]  flags;

  int pass_cnt  = 0;
  int total_cnt = 0;

  assign flags = {flag_zero, flag_carry, flag_ovf, flag_neg};

  gated_alu_pipe #(.WIDTH(8), .IDLE_CYCLES(4), .CNT_W(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .op           (op),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .flag_zero    (flag_zero),
    .flag_carry   (flag_carry),
    .flag_ovf     (flag_ovf),
    .flag_neg     (flag_neg),
    .clk_gated    (clk_gated),
    .gated_cycles (gated_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one beat with out_ready=1 and return after the edge where it reaches S2.
  task automatic send_one(input logic [7:0] va, input logic [7:0] vb, input logic [2:0] vop);
    in_valid  = 1'b1;
    a         = va;
    b         = vb;
    op        = vop;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; op = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (result !== 8'h00) $display("FAIL rst_result: got %h exp 00", result); else pass_cnt++;
    total_cnt++; if (flags !== 4'b0000) $display("FAIL rst_flags: got %b exp 0000", flags); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b exp 1", in_ready); else pass_cnt++;
    total_cnt++; if (clk_gated !== 1'b1) $display("FAIL rst_clk_gated: got %b exp 1", clk_gated); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    send_one(8'h05, 8'h03, 3'b000);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL add1_valid: got %b exp 1", out_valid); else pass_cnt++;
    total_cnt++; if (result !== 8'h08) $display("FAIL add1_result: got %h exp 08", result); else pass_cnt++;
    total_cnt++; if (flags !== 4'b0000) $display("FAIL add1_flags zcvn: got %b exp 0000", flags); else pass_cnt++;
    send_one(8'hFF, 8'h01, 3'b000);
    total_cnt++; if (result !== 8'h00) $display("FAIL add2_result: got %h exp 00", result); else pass_cnt++;
    total_cnt++; if (flags !== 4'b1100) $display("FAIL add2_flags zcvn: got %b exp 1100", flags); else pass_cnt++;
  endtask

  task automatic test_sub();
    send_one(8'h80, 8'h01, 3'b001);
    total_cnt++; if (result !== 8'h7F) $display("FAIL sub1_result: got %h exp 7f", result); else pass_cnt++;
    total_cnt++; if (flags !== 4'b0110) $display("FAIL sub1_flags zcvn: got %b exp 0110", flags); else pass_cnt++;
    send_one(8'h02, 8'h05, 3'b001);
    total_cnt++; if (result !== 8'hFD) $display("FAIL sub2_result: got %h exp fd", result); else pass_cnt++;
    total_cnt++; if (flags !== 4'b0001) $display("FAIL sub2_flags zcvn: got %b exp 0001", flags); else pass_cnt++;
  endtask

  task automatic test_misc_ops();
    send_one(8'hF0, 8'hFF, 3'b100);
    total_cnt++; if (result !== 8'h0F) $display("FAIL xor_result: got %h exp 0f", result); else pass_cnt++;
    total_cnt++; if (flags !== 4'b0000) $display("FAIL xor_flags zcvn: got %b exp 0000", flags); else pass_cnt++;
    send_one(8'h01, 8'h00, 3'b110);
    total_cnt++; if (result !== 8'h00) $display("FAIL shr_result: got %h exp 00", result); else pass_cnt++;
    total_cnt++; if (flags !== 4'b1100) $display("FAIL shr_flags zcvn: got %b exp 1100", flags); else pass_cnt++;
    send_one(8'h80, 8'h7F, 3'b111);
    total_cnt++; if (result !== 8'h80) $display("FAIL pass_result: got %h exp 80", result); else pass_cnt++;
    total_cnt++; if (flags !== 4'b0001) $display("FAIL pass_flags zcvn: got %b exp 0001", flags); else pass_cnt++;
    drain();
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [4] = '{8'h10, 8'hCC, 8'hC0, 8'h81};
    logic [7:0] vb [4] = '{8'h20, 8'hAA, 8'h03, 8'h00};
    logic [2:0] vo [4] = '{3'b000, 3'b010, 3'b011, 3'b101};
    logic [7:0] vr [4] = '{8'h30, 8'h88, 8'hC3, 8'h02};
    logic [3:0] vf [4] = '{4'b0000, 4'b0001, 4'b0001, 4'b0100};
    int         in_idx = 0;
    int         out_idx = 0;
    int         cyc = 0;
    int         k;
    logic       stalled = 1'b0;
    logic [7:0] held = '0;
    logic       exp_ir;
    while (out_idx < 4 && cyc < 40) begin
      k         = (in_idx < 4) ? in_idx : 3;
      in_valid  = (in_idx < 4);
      a         = va[k];
      b         = vb[k];
      op        = vo[k];
      out_ready = !(cyc >= 2 && cyc <= 4);
      #1;
      exp_ir = out_ready || ((in_idx - out_idx) < 2);
      total_cnt++; if (in_ready !== exp_ir) $display("FAIL b2b_in_ready cyc%0d: got %b exp %b", cyc, in_ready, exp_ir); else pass_cnt++;
      if (stalled) begin
        total_cnt++; if (result !== held) $display("FAIL b2b_stall_hold cyc%0d: got %h exp %h", cyc, result, held); else pass_cnt++;
      end
      if (out_valid && out_ready) begin
        total_cnt++; if (result !== vr[out_idx]) $display("FAIL b2b_result%0d: got %h exp %h", out_idx, result, vr[out_idx]); else pass_cnt++;
        total_cnt++; if (flags !== vf[out_idx]) $display("FAIL b2b_flags%0d zcvn: got %b exp %b", out_idx, flags, vf[out_idx]); else pass_cnt++;
        out_idx++;
      end
      stalled = out_valid && !out_ready;
      held    = result;
      if (in_valid && in_ready) in_idx++;
      if (out_idx < 4) begin
        @(posedge clk); #1;
      end
      cyc++;
    end
    in_valid = 1'b0;
    total_cnt++; if (out_idx != 4) $display("FAIL b2b_count: got %0d exp 4 results", out_idx); else pass_cnt++;
  endtask

  task automatic test_idle_gating();
    logic [15:0] g0;
    logic [15:0] exp_delta;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL idle_no_dup: got out_valid %b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (clk_gated !== 1'b0) $display("FAIL idle_open0: got %b exp 0", clk_gated); else pass_cnt++;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      total_cnt++; if (clk_gated !== 1'b0) $display("FAIL idle_open%0d: got %b exp 0", i, clk_gated); else pass_cnt++;
    end
    @(posedge clk); #1;
    total_cnt++; if (clk_gated !== 1'b1) $display("FAIL idle_closed: got %b exp 1", clk_gated); else pass_cnt++;
    g0 = gated_cycles;
    repeat (10) @(posedge clk);
    #1;
`ifdef GATE_STATS_EN
    exp_delta = 16'd10;
`else
    exp_delta = 16'd0;
`endif
    total_cnt++; if ((gated_cycles - g0) !== exp_delta) $display("FAIL idle_stats: got delta %0d exp %0d", gated_cycles - g0, exp_delta); else pass_cnt++;
    total_cnt++; if (clk_gated !== 1'b1) $display("FAIL idle_still_closed: got %b exp 1", clk_gated); else pass_cnt++;
    in_valid = 1'b1;
    a        = 8'h5A;
    b        = 8'h00;
    op       = 3'b111;
    #1;
    total_cnt++; if (clk_gated !== 1'b0) $display("FAIL wake_gate: got %b exp 0", clk_gated); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL wake_in_ready: got %b exp 1", in_ready); else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL wake_latency1: got out_valid %b exp 0", out_valid); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL wake_latency2: got out_valid %b exp 1", out_valid); else pass_cnt++;
    total_cnt++; if (result !== 8'h5A) $display("FAIL wake_result: got %h exp 5a", result); else pass_cnt++;
    drain();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 8'h01; b = 8'h01; op = 3'b000;
    @(posedge clk); #1;
    a = 8'h02; b = 8'h02;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL arst_full_valid: got %b exp 1", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL arst_full_in_ready: got %b exp 0", in_ready); else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL arst_drop_valid: got %b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (result !== 8'h00) $display("FAIL arst_result: got %h exp 00", result); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL arst_in_ready: got %b exp 1", in_ready); else pass_cnt++;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL arst_stale%0d: got out_valid %b exp 0", i, out_valid); else pass_cnt++;
    end
    total_cnt++; if (clk_gated !== 1'b1) $display("FAIL arst_gated: got %b exp 1", clk_gated); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_misc_ops();
    test_back_to_back();
    test_idle_gating();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/gated_alu_pipe.md
Name: gated_alu_pipe

Overview:
- Parametrised successor to the team's 4-bit clock-gated ALU.
- Two-stage pipelined ALU of WIDTH bits with a valid/ready handshake on input and output, an extended op set and a full flag set.
- Pipeline registers sit behind an internal clock gate that closes automatically after a programmable idle window.
- Used as the datapath core in low-power blocks that replaces the manual enable-gated ALU.

Parameters:
- WIDTH, 8, operand/result width; minimum 2.
- IDLE_CYCLES, 4, free-clock cycles with no activity before the gate closes; minimum 1.
- CNT_W, 16, width of the gated-cycle counter (used only with GATE_STATS_EN).

Ports:
- clk  in  1  free-running clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  3  operation select
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  registered result
- flag_zero, flag_carry, flag_ovf, flag_neg  out  1 each  registered flags, qualified by out_valid
- clk_gated  out  1  1 while the pipeline clock is gated off
- gated_cycles  out  CNT_W  gated-cycle count (GATE_STATS_EN only)

Behaviour:
- Reset: reset_n low asynchronously clears s1_valid, s2_valid, result, all flags and idle_cnt.
  - Outputs after reset: out_valid=0, in_ready=1, result=0, flags=0, clk_gated=1 while in_valid=0.
  - Reset mid-operation discards all in-flight beats; no output is produced for them.
- Stages:
  - S1 registers a, b, op on an input handshake (in_valid & in_ready).
  - S2 registers the computed result and flags from S1.
- Advance rules:
  - s1_adv = !s2_valid | out_ready.
  - in_ready = !s1_valid | s1_adv (combinational; depends on out_ready).
  - s2_valid is set on s1_adv & s1_valid; it clears on an output handshake when S1 is empty.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+1. Throughput is 1 beat/cycle while out_ready=1.
- Backpressure:
  - While out_valid & !out_ready, result and flags hold stable.
  - S1 holds; in_ready=0 once S1 is occupied. No beat is lost or duplicated.
- Simultaneous input and output handshake in the same cycle with both stages full: both stages shift and stay full.
- Ops (mod 2^WIDTH):
  - 000 ADD: carry = carry-out.
  - 001 SUB (a-b): carry = NOT borrow.
  - 010 AND, 011 OR, 100 XOR: carry=0, ovf=0.
  - 101 SHL by 1: carry = a[MSB].
  - 110 SHR logical by 1: carry = a[0].
  - 111 PASS A: carry=0.
- Flags:
  - ovf = signed overflow for ADD/SUB, else 0.
  - zero = (result==0).
  - neg = result[MSB].
- Clock gate:
  - gate_en = in_valid | s1_valid | s2_valid | (idle_cnt != 0).
  - idle_cnt runs on the free clock: it loads IDLE_CYCLES on any cycle with in_valid, s1_valid or s2_valid, otherwise decrements to 0 and saturates there.
  - The pipeline clock is clk ANDed with the latched gate_en. The latch is transparent while clk is low, so the gated clock is glitch-free.
  - clk_gated = !gate_en (combinational).
  - in_valid rising while gated re-opens the gate before the next rising edge, so the first beat is accepted with zero added latency.

Optional Feature:
- Macro: GATE_STATS_EN.
- Defined:
  - gated_cycles (CNT_W) increments on each free-clock edge where clk_gated=1.
  - It saturates at all-ones and clears on reset.
- Undefined: gated_cycles is tied to 0 and no counter logic is synthesised; all other behaviour is identical.

Test Plan:
- Reset check: hold reset_n=0 for 3 cycles, then release with in_valid=0 → out_valid=0, result=0, in_ready=1, clk_gated=1.
- ADD: a=0x05, b=0x03, op=000 → after 2 edges result=0x08, flags all 0.
  - Then a=0xFF, b=0x01 → result=0x00, zero=1, carry=1, ovf=0.
- SUB/overflow: a=0x80, b=0x01, op=001 → result=0x7F, ovf=1, carry=1, neg=0.
  - Then a=0x02, b=0x05 → result=0xFD, carry=0, neg=1.
- Back-to-back with backpressure: stream 4 beats (ADD, AND 0xCC&0xAA=0x88, OR 0xC0|0x03=0xC3, SHL 0x81→0x02 with carry=1). Drop out_ready for 3 cycles mid-stream.
  - Expect: results in order, none lost or duplicated, result stable while stalled, in_ready=0 while both stages are full.
- Idle gating (IDLE_CYCLES=4): after the last output handshake with in_valid=0, clk_gated rises 4 cycles later.
  - With GATE_STATS_EN: gated_cycles increments by 10 over 10 idle cycles.
  - Then in_valid=1 → clk_gated=0 in the same cycle and the beat is accepted at the next edge.
- Async reset mid-stream: assert reset_n low between edges with both stages full → out_valid drops immediately.
  - After release, no stale result appears.
